// File: rtl/minmax_frame_tx.sv
// minmax_frame_tx: captures the final max/min from the scan stage when its
// done rises. It then sends a 6-byte result frame on a valid/ready byte
// stream: header, max, min, range, seq, checksum.
module minmax_frame_tx #(
  parameter logic [7:0]  HEADER = 8'hA5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              done,
  input  logic [DATA_W-1:0] max,
  input  logic [DATA_W-1:0] min,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        seq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]        state;
  logic              done_d;
  logic              rise;
  logic [DATA_W-1:0] cap_max;
  logic [DATA_W-1:0] cap_min;
  logic [7:0]        cap_seq;
  logic [2:0]        idx;
  logic [DATA_W-1:0] range_val;
  logic [7:0]        checksum;
  logic [7:0]        next_byte;
  logic              accept;

  assign rise   = done & ~done_d;
  assign accept = tx_valid & tx_ready;

  // Range saturates at zero rather than wrapping when min exceeds max.
  always_comb begin
    range_val = '0;
    if (cap_min <= cap_max)
      range_val = cap_max - cap_min;
  end

  // Checksum depends only on captured registers, so it holds steady for the whole frame.
  always_comb begin
    checksum = HEADER ^ cap_max ^ cap_min ^ range_val ^ cap_seq;
  end

  // Byte that follows the one currently on tx_data (frame position idx+1).
  always_comb begin
    next_byte = HEADER;
    case (idx)
      3'd0:    next_byte = cap_max;
      3'd1:    next_byte = cap_min;
      3'd2:    next_byte = range_val;
      3'd3:    next_byte = cap_seq;
      3'd4:    next_byte = checksum;
      default: next_byte = HEADER;
    endcase
  end

  // Edge detection, capture, frame sequencing and overrun tracking.
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state    <= S_IDLE;
      done_d   <= 1'b0;
      cap_max  <= '0;
      cap_min  <= '0;
      cap_seq  <= '0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      seq      <= '0;
    end else begin
      done_d <= done;
      // Any rise outside IDLE is dropped, including one on the cycle busy falls.
      if (rise && state != S_IDLE)
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rise)
            state <= S_ARM;
        end
        S_ARM: begin
          // The scan results settle one cycle after done, so capture them here.
          cap_max  <= max;
          cap_min  <= min;
          cap_seq  <= seq;
          busy     <= 1'b1;
          idx      <= '0;
          tx_data  <= HEADER;
          tx_valid <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (accept) begin
            if (idx == 3'd5) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              seq      <= seq + 8'd1;
              state    <= S_IDLE;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= next_byte;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_frame_tx.sv
// Testbench for minmax_frame_tx: it drives random and directed frames and
// compares them against a frame model written from the rules.
module tb_minmax_frame_tx;

  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       nRST = 1'b1;
  logic       done = 1'b0;
  logic [7:0] max = '0;
  logic [7:0] min = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       overrun;
  logic [7:0] seq;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q [6];
  logic [7:0] exp_q [6];
  int         got_n;
  int         first_c;
  int         vcyc;
  logic       busy_first;
  logic [7:0] exp_seq;

  minmax_frame_tx #(.HEADER(8'hA5), .DATA_W(8)) dut (
    .clk(clk), .nRST(nRST), .done(done), .max(max), .min(min),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .seq(seq)
  );

  always #5 clk = ~clk;

  // Reference frame, built directly from the frame rules.
  task automatic model_frame(input logic [7:0] mx, input logic [7:0] mn, input logic [7:0] sq);
    logic [7:0] rng;
    rng = (mn > mx) ? 8'h00 : 8'(mx - mn);
    exp_q[0] = HDR;
    exp_q[1] = mx;
    exp_q[2] = mn;
    exp_q[3] = rng;
    exp_q[4] = sq;
    exp_q[5] = HDR ^ mx ^ mn ^ rng ^ sq;
  endtask

  // Raises done, feeds the results one cycle late and collects the six accepted bytes.
  task automatic run_frame(input logic [7:0] mx, input logic [7:0] mn, input int stall_idx,
                           input int stall_n, input bit rnd, input int pulse_idx);
    int stall_left;
    int pulse_st;
    bit pv;
    bit pr;
    logic [7:0] pd;
    stall_left = stall_n;
    pulse_st = 0;
    pv = 1'b0;
    pr = 1'b1;
    pd = '0;
    got_n = 0;
    first_c = -1;
    vcyc = 0;
    busy_first = 1'b0;
    @(negedge clk);
    done = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    done = 1'b1;
    max = 8'($urandom);
    min = 8'($urandom);
    for (int c = 1; c < 300 && got_n < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        max = mx;
        min = mn;
      end
      if (pulse_st == 1) begin
        done = 1'b1;
        pulse_st = 2;
      end
      if (pv && !pr) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, pd);
        end
      end
      pv = tx_valid;
      pd = tx_data;
      if (tx_valid === 1'b1) begin
        vcyc++;
        if (first_c < 0) begin
          first_c = c;
          busy_first = busy;
        end
        if (pulse_idx >= 0 && pulse_st == 0 && got_n == pulse_idx) begin
          done = 1'b0;
          pulse_st = 1;
        end
        if (stall_left > 0 && got_n == stall_idx) begin
          pr = 1'b0;
          stall_left--;
        end else if (rnd) begin
          pr = 1'($urandom_range(0, 1));
        end else begin
          pr = 1'b1;
        end
        tx_ready = pr;
        if (pr) begin
          got_q[got_n] = tx_data;
          got_n++;
        end
      end else begin
        pr = 1'b1;
        tx_ready = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (got_n != 6) begin
      errors++;
      $display("FAIL frame_timeout: bytes=%0d, required 6", got_n);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    done = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b0;
    exp_seq = 8'h00;
    @(negedge clk);
  endtask

  task automatic compare_frame(input string name);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte%0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    #1;
    checks++;
    if ({tx_data, tx_valid, busy, overrun, seq} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: data=%h valid=%b busy=%b ovr=%b seq=%h, required all 0",
               tx_data, tx_valid, busy, overrun, seq);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int seen;
    run_frame(8'hC8, 8'h14, -1, 0, 1'b0, -1);
    model_frame(8'hC8, 8'h14, exp_seq);
    compare_frame("basic");
    checks++;
    if (got_q[3] !== 8'hB4 || got_q[5] !== 8'hCD) begin
      errors++;
      $display("FAIL basic_const: range=%h chk=%h, required B4 CD", got_q[3], got_q[5]);
    end
    checks++;
    if (first_c != 2) begin
      errors++;
      $display("FAIL latency: first valid at %0d, required 2", first_c);
    end
    checks++;
    if (vcyc != 6 || busy_first !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid: cycles=%0d busy=%b, required 6 1", vcyc, busy_first);
    end
    exp_seq = exp_seq + 8'd1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || seq !== exp_seq) begin
      errors++;
      $display("FAIL basic_end: busy=%b valid=%b seq=%h, required 0 0 %h", busy, tx_valid, seq, exp_seq);
    end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL no_retrigger: valid cycles %0d, required 0", seen);
    end
  endtask

  task automatic test_backpressure();
    run_frame(8'hC8, 8'h14, 2, 3, 1'b0, -1);
    model_frame(8'hC8, 8'h14, exp_seq);
    compare_frame("backpressure");
    checks++;
    if (vcyc != 9) begin
      errors++;
      $display("FAIL bp_cycles: valid cycles %0d, required 9", vcyc);
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_min_gt_max();
    run_frame(8'h10, 8'h20, -1, 0, 1'b0, -1);
    model_frame(8'h10, 8'h20, exp_seq);
    compare_frame("min_gt_max");
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_overrun();
    int seen;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: got %b, required 0", overrun);
    end
    run_frame(8'h77, 8'h33, -1, 0, 1'b0, 3);
    model_frame(8'h77, 8'h33, exp_seq);
    compare_frame("overrun_frame");
    exp_seq = exp_seq + 8'd1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || overrun !== 1'b1 || seq !== exp_seq) begin
      errors++;
      $display("FAIL overrun_post: extra valid=%0d ovr=%b seq=%h, required 0 1 %h", seen, overrun, seq, exp_seq);
    end
    run_frame(8'h05, 8'h01, -1, 0, 1'b1, -1);
    model_frame(8'h05, 8'h01, exp_seq);
    compare_frame("after_overrun");
    exp_seq = exp_seq + 8'd1;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask

  task automatic test_random();
    logic [7:0] mx;
    logic [7:0] mn;
    for (int n = 0; n < 20; n++) begin
      mx = 8'($urandom);
      mn = 8'($urandom);
      run_frame(mx, mn, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b1, -1);
      model_frame(mx, mn, exp_seq);
      compare_frame("random");
      exp_seq = exp_seq + 8'd1;
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    done = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    done = 1'b1;
    max = 8'h99;
    min = 8'h11;
    repeat (4) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      errors++;
      $display("FAIL mid_pre: valid=%b data=%h, required 1 11", tx_valid, tx_data);
    end
    nRST = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || seq !== 8'h00) begin
      errors++;
      $display("FAIL mid_async: valid=%b busy=%b seq=%h, required 0 0 00", tx_valid, busy, seq);
    end
    repeat (2) @(negedge clk);
    done = 1'b0;
    nRST = 1'b0;
    exp_seq = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_partial: valid=%b, required 0", tx_valid);
    end
    run_frame(8'h42, 8'h02, -1, 0, 1'b0, -1);
    model_frame(8'h42, 8'h02, 8'h00);
    compare_frame("after_reset");
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_seq_wrap();
    logic [7:0] mx;
    logic [7:0] mn;
    do_reset();
    for (int n = 0; n < 256; n++) begin
      mx = 8'($urandom);
      mn = 8'($urandom);
      run_frame(mx, mn, -1, 0, 1'b0, -1);
      model_frame(mx, mn, exp_seq);
      if (n == 0 || n == 255) compare_frame("wrap");
      else begin
        checks++;
        if (got_q[4] !== exp_q[4] || got_q[5] !== exp_q[5]) begin
          errors++;
          $display("FAIL wrap_seq: seq=%h chk=%h, required %h %h", got_q[4], got_q[5], exp_q[4], exp_q[5]);
        end
      end
      exp_seq = exp_seq + 8'd1;
    end
    checks++;
    if (got_q[4] !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_last: got %h, required FF", got_q[4]);
    end
    @(negedge clk);
    checks++;
    if (seq !== 8'h00) begin
      errors++;
      $display("FAIL wrap_seq_out: got %h, required 00", seq);
    end
    run_frame(8'h80, 8'h7F, -1, 0, 1'b0, -1);
    model_frame(8'h80, 8'h7F, 8'h00);
    compare_frame("post_wrap");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_min_gt_max();
    test_overrun();
    test_random();
    test_reset_mid_frame();
    test_seq_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/minmax_frame_tx.md
Name: minmax_frame_tx

Overview:
- Downstream consumer of the max/min scan stage.
- Waits for the scan's done to rise, then captures the final max/min results.
- Derives range = max-min and emits a 6-byte result frame on a valid/ready byte stream toward the host/UART side.
- Tracks a frame sequence number and flags scans completed while a frame is still in flight.

Parameters:
- HEADER, 8'hA5, first byte of every frame
- DATA_W, 8, width of max/min/tx_data (frame layout assumes 8)

Ports:
- clk  input  1  system clock, all state on rising edge
- nRST  input  1  reset, asynchronous, active-high (asserted = 1)
- done  input  1  scan-complete level from scan stage; stays high once set
- max  input  DATA_W  final maximum from scan stage
- min  input  DATA_W  final minimum from scan stage
- tx_data  output  8  frame byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts byte when tx_valid & tx_ready at rising edge
- busy  output  1  high from capture until last byte accepted
- overrun  output  1  sticky: new done rise seen while busy
- seq  output  8  sequence number of next frame to send

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (nRST=1, takes effect immediately, no clock needed): tx_data=0, tx_valid=0, busy=0, overrun=0, seq=0, state=IDLE, done history regs=0, captured regs=0.
- Edge detect: done_d <= done each cycle; rise = done & ~done_d.
- max/min from the scan stage update one cycle after done first goes high, so capture is delayed one cycle.
- FSM states:
  - IDLE: on rise -> ARM.
  - ARM (1 cycle): cap_max<=max, cap_min<=min, cap_seq<=seq, busy<=1 -> SEND, idx=0.
  - SEND: drive byte idx; advance on handshake; after idx 5 accepted -> IDLE.
- Frame byte order:
  - 0 HEADER
  - 1 cap_max
  - 2 cap_min
  - 3 range
  - 4 cap_seq
  - 5 XOR of bytes 0..4
- range = cap_max - cap_min (8-bit); if cap_min > cap_max then range = 8'h00 (no wrap).
- Checksum is computed combinationally from captured regs and is stable throughout the frame.
- Handshake:
  - tx_valid=1 and tx_data registered on the cycle SEND is entered.
  - tx_data must not change while tx_valid & ~tx_ready.
  - tx_valid must not drop before acceptance.
  - Zero-wait acceptance gives back-to-back bytes: frame occupies exactly 6 cycles of tx_valid.
- Latency: done rise at cycle T → byte 0 valid at T+2.
- Last byte accepted:
  - same edge: tx_valid<=0, busy<=0, seq<=seq+1 (wraps 0xFF->0x00).
  - IDLE may accept a new rise on the following cycle.
- Rise while busy (ARM or SEND): frame in flight unaffected, rise dropped, overrun<=1.
- overrun is sticky until reset.
- Rise on the same cycle busy falls counts as while busy (dropped, overrun set).
- done held high: no retrigger. done must return low and rise again for a new frame.
- Reset mid-frame: frame abandoned, seq not incremented (returns to 0), no partial byte after release.

Test Plan:
- Basic frame: reset, max=0xC8, min=0x14, done 0->1, tx_ready=1 → bytes A5 C8 14 B4 00 CD on 6 consecutive cycles; first valid 2 cycles after done rise; busy falls with last byte; seq=1.
- Backpressure: same inputs, tx_ready low 3 cycles on byte 2 → tx_data held at 0x14 with tx_valid=1, sequence completes unchanged, no duplicate or skipped bytes.
- min>max: max=0x10, min=0x20 → range byte 00, checksum A5^10^20^00^seq.
- Overrun: second done rise (pulse low then high) during byte 3 → current frame completes intact, no second frame, overrun=1 and stays 1.
- Seq wrap: run 256 frames → frame 256 carries seq byte FF; afterward seq=00; next frame byte 4 = 00.
- Reset mid-frame: nRST=1 during byte 2 → tx_valid, busy, seq drop to 0 without clock edge; after release plus a new done rise, full frame starts at byte A5 with seq 00.
